// File: rtl/controller_pkg.sv
// Shared definitions for the dispatch controller and its counting partner.
// Contents: FSM state encoding, response status codes, default parameter
// values, and the run-length constant used by the counting controller.
package controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_GAP  = 2'b10,
    ST_RESP = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    STAT_OK      = 2'b00,
    STAT_TIMEOUT = 2'b01,
    STAT_ABORT   = 2'b10
  } status_t;

  localparam int DEF_REP_W          = 8;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  // Cycles per run in the counting controller that consumes start.
  localparam int WIDTH = 16;

endpackage

// File: rtl/dispatch_wdt.sv
// Per-run watchdog for controller_dispatch.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : reload the timer (asserted on the cycle before RUN entry)
//   en         : count enable (high while in RUN)
//   expired    : high during the TIMEOUT_CYCLES-th enabled cycle
module dispatch_wdt #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Down-counter: loaded with TIMEOUT_CYCLES-1 so the terminal count (0)
  // coincides with the last allowed cycle in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= LOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = en && (cnt == '0);

endmodule

// File: rtl/controller_dispatch.sv
// Job dispatcher: accepts a job of N runs, enables the counting controller
// once per run (with a one-cycle gap between runs), and returns a result.
// Optional per-run watchdog enabled by macro CONTROLLER_DISPATCH_TIMEOUT_EN.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : job request handshake, req_repeat = runs (0 -> 1)
//   abort                : cancel active job (RUN/GAP only)
//   start / done         : run enable out, run complete in
//   rsp_valid/rsp_ready  : result handshake; rsp_status, rsp_runs held in RESP
//   busy                 : FSM not in IDLE
//
// state | meaning
// IDLE  | waiting for a request, req_ready=1
// RUN   | start=1, waiting for done (or abort / timeout)
// GAP   | one low cycle between consecutive runs
// RESP  | result presented until rsp_ready
module controller_dispatch
  import controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int REP_W          = DEF_REP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [REP_W-1:0] req_repeat,
  input  logic             abort,
  output logic             start,
  input  logic             done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_status,
  output logic [REP_W-1:0] rsp_runs,
  output logic             busy
);

  state_t           state_q, state_d;
  status_t          status_q, status_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [REP_W-1:0] runs_q, runs_d;
  logic [REP_W-1:0] runs_inc;
  logic             start_q, rsp_valid_q;
  logic             wdt_expired;

`ifdef CONTROLLER_DISPATCH_TIMEOUT_EN
  logic wdt_clr;

  assign wdt_clr = (state_d == ST_RUN) && (state_q != ST_RUN);

  dispatch_wdt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wdt_clr),
    .en     (state_q == ST_RUN),
    .expired(wdt_expired)
  );
`else
  assign wdt_expired = 1'b0;
`endif

  // runs_q never exceeds rep_q-1 while in RUN, so the increment cannot wrap.
  assign runs_inc = runs_q + REP_W'(1);

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    rep_d    = rep_q;
    runs_d   = runs_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rep_d   = (req_repeat == '0) ? REP_W'(1) : req_repeat;
          runs_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // done is counted before abort or timeout are considered
        if (done) begin
          runs_d = runs_inc;
          if (runs_inc == rep_q) begin
            state_d  = ST_RESP;
            status_d = STAT_OK;
          end else if (abort) begin
            state_d  = ST_RESP;
            status_d = STAT_ABORT;
          end else begin
            state_d = ST_GAP;
          end
        end else if (abort) begin
          state_d  = ST_RESP;
          status_d = STAT_ABORT;
        end else if (wdt_expired) begin
          state_d  = ST_RESP;
          status_d = STAT_TIMEOUT;
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_d  = ST_RESP;
          status_d = STAT_ABORT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      status_q    <= STAT_OK;
      rep_q       <= '0;
      runs_q      <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      rep_q       <= rep_d;
      runs_q      <= runs_d;
      start_q     <= (state_d == ST_RUN);
      rsp_valid_q <= (state_d == ST_RESP);
    end
  end

  assign start      = start_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_status = status_q;
  assign rsp_runs   = runs_q;
  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_controller_dispatch.sv
module tb_controller_dispatch;

  localparam int TMO = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_repeat = '0;
  logic       abort = 1'b0;
  logic       start;
  logic       done = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [1:0] rsp_status;
  logic [7:0] rsp_runs;
  logic       busy;

  int checks = 0;
  int errors = 0;

  controller_dispatch #(.TIMEOUT_CYCLES(TMO), .REP_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_repeat(req_repeat),
    .abort(abort), .start(start), .done(done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_runs(rsp_runs), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rep;
    int         run_len;    // done pulsed on this start-high cycle; 0 = never
    int         abort_run;  // run index (1-based) receiving abort; 0 = none
    int         abort_cyc;  // start-high cycle of that run carrying abort
    int         hold;       // cycles rsp_ready is held low
    logic [1:0] exp_status;
    logic [7:0] exp_runs;
    int         exp_win;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", rsp_valid, 0);
    chk("req_ready_after_hs", req_ready, 1);
    chk("busy_after_hs", busy, 0);
  endtask

  // Called at a negedge; acts as the counting controller for one job.
  task automatic do_job(input vec_t v);
    int  hi, win, gap, exp_len;
    bit  got;
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_repeat = v.rep;
    @(negedge clk);
    req_valid = 1'b0; req_repeat = '0;
    chk("start_after_accept", start, 1);
    hi = 0; win = 0; gap = 0; got = 0;
    for (int cyc = 0; cyc < 3000 && !got; cyc++) begin
      if (cyc > 0) @(negedge clk);
      done = 1'b0; abort = 1'b0;
      if (!start && hi > 0) begin
        win++;
        if (win == v.abort_run) exp_len = v.abort_cyc;
        else if (v.run_len == 0) exp_len = TMO;
        else exp_len = v.run_len;
        chk("window_len", hi, exp_len);
        hi = 0; gap = 0;
      end
      if (rsp_valid) begin
        got = 1;
        chk("rsp_follows_start", gap, 0);
      end else if (start) begin
        if (hi == 0 && win > 0) chk("gap_len", gap, 1);
        hi++;
        if (v.run_len != 0 && hi == v.run_len) done = 1'b1;
        if (win + 1 == v.abort_run && hi == v.abort_cyc) abort = 1'b1;
      end else begin
        gap++;
      end
    end
    if (!got) chk("rsp_timeout", 0, 1);
    chk("rsp_status", rsp_status, v.exp_status);
    chk("rsp_runs", rsp_runs, v.exp_runs);
    chk("windows", win, v.exp_win);
    chk("start_low_in_resp", start, 0);
    // done/abort are driven during the hold to show they are ignored in RESP
    for (int i = 0; i < v.hold; i++) begin
      done = 1'b1; abort = 1'b1;
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_status", rsp_status, v.exp_status);
      chk("hold_runs", rsp_runs, v.exp_runs);
      chk("hold_req_ready", req_ready, 0);
    end
    done = 1'b0; abort = 1'b0;
    handshake();
  endtask

  initial begin
    //           rep  len ar ac hold st     runs win
    vecs[0] = '{8'd1,  16, 0, 0, 0,  2'b00, 8'd1,   1};
    vecs[1] = '{8'd3,  16, 0, 0, 0,  2'b00, 8'd3,   3};
    vecs[2] = '{8'd4,  16, 3, 5, 0,  2'b10, 8'd2,   3};
    vecs[3] = '{8'd0,   4, 0, 0, 0,  2'b00, 8'd1,   1};
    vecs[4] = '{8'd2,   3, 1, 3, 0,  2'b10, 8'd1,   1};
    vecs[5] = '{8'd2,   3, 2, 3, 0,  2'b00, 8'd2,   2};
    vecs[6] = '{8'd1,   5, 0, 0, 10, 2'b00, 8'd1,   1};
    vecs[7] = '{8'd2,   1, 0, 0, 2,  2'b00, 8'd2,   2};
    vecs[8] = '{8'd255, 1, 0, 0, 0,  2'b00, 8'd255, 255};

    #2;
    chk("rst_start", start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_status", rsp_status, 0);
    chk("rst_runs", rsp_runs, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // done/abort in IDLE are ignored
    done = 1'b1; abort = 1'b1;
    @(negedge clk);
    done = 1'b0; abort = 1'b0;
    chk("idle_ignore_busy", busy, 0);
    chk("idle_ignore_rsp", rsp_valid, 0);
    chk("idle_ignore_runs", rsp_runs, 0);

    for (int i = 0; i < 9; i++) do_job(vecs[i]);

    // abort during GAP
    req_valid = 1'b1; req_repeat = 8'd3;
    @(negedge clk);
    req_valid = 1'b0;
    chk("gap_start1", start, 1);
    @(negedge clk);
    chk("gap_start2", start, 1);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("gap_start_low", start, 0);
    chk("gap_no_rsp", rsp_valid, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("gap_abort_valid", rsp_valid, 1);
    chk("gap_abort_status", rsp_status, 2'b10);
    chk("gap_abort_runs", rsp_runs, 1);
    chk("gap_abort_start", start, 0);
    handshake();

`ifdef CONTROLLER_DISPATCH_TIMEOUT_EN
    do_job('{8'd2, 0, 0, 0, 0, 2'b01, 8'd0, 1});
`else
    // without the watchdog RUN waits indefinitely
    req_valid = 1'b1; req_repeat = 8'd1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!start || rsp_valid) begin
        chk("no_wdt_still_running", {start, rsp_valid}, 2'b10);
        break;
      end
      @(negedge clk);
    end
    chk("no_wdt_start", start, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("no_wdt_abort_status", rsp_status, 2'b10);
    chk("no_wdt_abort_runs", rsp_runs, 0);
    handshake();
`endif

    // reset mid-run
    req_valid = 1'b1; req_repeat = 8'd2;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_rst_running", start, 1);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_start", start, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rsp", rsp_valid, 0);
    chk("mid_rst_runs", rsp_runs, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    do_job('{8'd1, 3, 0, 0, 0, 2'b00, 8'd1, 1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/controller_dispatch.md
CONTROLLER_DISPATCH -- requirements
Module: controller_dispatch

Interface
REQ-001 Parameters (name, default, meaning): the block SHALL have exactly these parameters.
- TIMEOUT_CYCLES, 64: max cycles per run with start high before timeout.
- REP_W, 8: width of the repeat count and completed-run count.

REQ-002 Ports (name, direction, width, meaning): the block SHALL have exactly these ports.
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- req_valid, in, 1: job request valid.
- req_ready, out, 1: job request accepted.
- req_repeat, in, REP_W: runs requested; 0 is treated as 1.
- abort, in, 1: cancel the active job.
- start, out, 1: run enable toward the counting controller.
- done, in, 1: run complete, from the counting controller.
- rsp_valid, out, 1: job result valid.
- rsp_ready, in, 1: result consumed.
- rsp_status, out, 2: result code; 00 OK, 01 TIMEOUT, 10 ABORT.
- rsp_runs, out, REP_W: runs completed with done.
- busy, out, 1: high in any state other than IDLE.

Function
REQ-003 FSM states SHALL be IDLE, RUN, GAP and RESP, all registered.
REQ-004 req_ready SHALL be 1 only in IDLE.
REQ-005 A request SHALL be accepted when req_valid&req_ready at edge N; req_repeat is latched, the run counter cleared, and the state moves to RUN, so start=1 from cycle N+1.
REQ-006 start SHALL be registered and equal 1 only in RUN.
REQ-007 In RUN, done=1 sampled at edge M SHALL increment rsp_runs and drop start at M+1.
REQ-008 If runs remain after that done, the next state SHALL be GAP for exactly 1 cycle, then RUN; start is low for exactly one cycle between runs.
REQ-009 If no runs remain after that done, the next state SHALL be RESP with status OK; rsp_valid=1 from M+1.
REQ-010 done SHALL be ignored in IDLE, GAP and RESP.
REQ-011 In RESP, rsp_valid, rsp_status and rsp_runs SHALL hold stable until rsp_valid&rsp_ready; the state then returns to IDLE, with req_ready=1 on the next cycle.
REQ-012 abort=1 in RUN or GAP SHALL move the state to RESP with status ABORT, start=0 on the next cycle, and rsp_runs equal to the runs completed so far.
REQ-013 abort SHALL be ignored in IDLE and RESP.
REQ-014 If done and abort are high in the same RUN cycle, the run SHALL be counted first; status is OK if that was the last run, else ABORT.
REQ-015 If done and timeout coincide, done SHALL win.
REQ-016 Run and repeat counters SHALL be REP_W bits with no wrap; a repeat of 2^REP_W-1 runs to completion.

Reset
REQ-017 While rst_n=0, the block SHALL force state=IDLE, start=0, rsp_valid=0, rsp_status=00, rsp_runs=0, busy=0 and all counters to 0; req_ready SHALL be 1.
REQ-018 Reset asserted mid-job SHALL drop start asynchronously and discard the job with no response.
REQ-019 After deassertion, the first request SHALL be acceptable on the first clock edge.

Configuration
REQ-020 With macro CONTROLLER_DISPATCH_TIMEOUT_EN defined, a per-run watchdog SHALL count the cycles spent in RUN, cleared on each RUN entry.
REQ-021 When the watchdog reaches TIMEOUT_CYCLES without done, the next state SHALL be RESP with status TIMEOUT and start=0.
REQ-022 Without the macro, the watchdog logic SHALL be absent, RUN waits indefinitely, and status 01 is never produced.

Structure
REQ-023 Shared package controller_pkg SHALL hold:
- the state enum typedef;
- the rsp_status enum (OK, TIMEOUT, ABORT);
- the default REP_W and TIMEOUT_CYCLES constants;
- the WIDTH run-length constant used by the counting controller.
REQ-024 The watchdog SHALL be a sub-module named dispatch_wdt (inputs clr, en; output expired), instantiated only under the macro.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- req_repeat=1, done pulsed after 16 start cycles -> start high exactly 16 cycles; rsp_valid next cycle; status 00; rsp_runs=1.
- req_repeat=3, done after 16 cycles per run -> three start windows, each separated by exactly one low cycle; status 00; rsp_runs=3.
- req_repeat=4, abort during run 3 -> start low next cycle; status 10; rsp_runs=2.
- Macro defined, TIMEOUT_CYCLES=64, done never asserted -> start drops after 64 cycles; status 01; rsp_runs=0.
- rsp_ready held low for 10 cycles -> rsp fields stable; req_ready=0 throughout; req_ready=1 the cycle after the handshake.
- rst_n asserted mid-run -> start=0 immediately; no rsp_valid; next request accepted normally.
